// File: rtl/noc_alloc_pkg.sv
// Shared definitions for the NoC switch allocator: occupied-entry layout,
// width helper and assertion messages.
package noc_alloc_pkg;

  // occupied entry per output is {busy, owner}; owner sits at the LSBs
  localparam int OCC_OWNER_OFS = 0;

  function automatic int occ_busy_ofs(input int log_ports);
    return log_ports;
  endfunction

  function automatic int occ_w(input int log_ports);
    return log_ports + 1;
  endfunction

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int k = 0; k < 32; k++)
      if ((1 << r) < n) r++;
    return (r == 0) ? 1 : r;
  endfunction

  localparam string MSG_ORPHAN   = "alloc: non-head flit without a matching output lock";
  localparam string MSG_CRED_OVF = "alloc: credit_in received with counter already full";

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first requester at or above ptr wins, wrapping at N-1.
module rr_arbiter
  import noc_alloc_pkg::*;
#(
  parameter int N  = 5,
  parameter int PW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  int idx;

  // walk offsets from far to near so the nearest requester is the last write
  always_comb begin
    gnt = '0;
    idx = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (req[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_switch_allocator.sv
// Per-VC switch allocator: round-robin per output, wormhole locks, credit
// counters and a registered crossbar stage.
module rr_switch_allocator
  import noc_alloc_pkg::*;
#(
  parameter int PORTS        = 5,
  parameter int LOG_PORTS    = 3,
  parameter int FLIT_W       = 32,
  parameter int CREDIT_DEPTH = 4,
  parameter int CRED_W       = 3
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [PORTS-1:0]                   in_valid,
  input  logic [PORTS*LOG_PORTS-1:0]         in_dst,
  input  logic [PORTS-1:0]                   in_head,
  input  logic [PORTS-1:0]                   in_tail,
  input  logic [PORTS*FLIT_W-1:0]            in_flit,
  output logic [PORTS-1:0]                   in_pop,
  output logic [PORTS-1:0]                   out_valid,
  output logic [PORTS*FLIT_W-1:0]            out_flit,
  input  logic [PORTS-1:0]                   credit_in,
  output logic [PORTS*(1+LOG_PORTS)-1:0]     occupied
);

  localparam int OCC_W = occ_w(LOG_PORTS);

  logic [PORTS-1:0][LOG_PORTS-1:0] dst, owner, ptr, win;
  logic [PORTS-1:0][CRED_W-1:0]    credit;
  logic [PORTS-1:0][FLIT_W-1:0]    win_flit, flit_q;
  logic [PORTS-1:0][PORTS-1:0]     req, gnt;
  logic [PORTS-1:0]                busy, mine, elig, orphan, pop_c;
  logic [PORTS-1:0]                gnt_any, win_head, win_tail;

  for (genvar i = 0; i < PORTS; i++) begin : g_dst
    assign dst[i] = in_dst[i*LOG_PORTS +: LOG_PORTS];
  end

  always_comb begin
    for (int i = 0; i < PORTS; i++) begin
      mine[i]   = 1'b0;
      elig[i]   = 1'b0;
      orphan[i] = 1'b0;
      if (int'(dst[i]) < PORTS) begin
        mine[i]   = busy[dst[i]] && (owner[dst[i]] == LOG_PORTS'(i));
        elig[i]   = in_valid[i] && (credit[dst[i]] != '0) &&
                    ((!busy[dst[i]] && in_head[i]) || mine[i]);
        orphan[i] = in_valid[i] && !in_head[i] && !mine[i];
      end
    end
  end

  always_comb begin
    for (int o = 0; o < PORTS; o++)
      for (int i = 0; i < PORTS; i++)
        req[o][i] = elig[i] && (dst[i] == LOG_PORTS'(o));
  end

  for (genvar o = 0; o < PORTS; o++) begin : g_arb
    rr_arbiter #(.N(PORTS), .PW(LOG_PORTS)) u_arb (
      .req (req[o]),
      .ptr (ptr[o]),
      .gnt (gnt[o])
    );
  end

  always_comb begin
    pop_c = '0;
    for (int o = 0; o < PORTS; o++) begin
      gnt_any[o]  = |gnt[o];
      win[o]      = '0;
      win_flit[o] = '0;
      win_head[o] = 1'b0;
      win_tail[o] = 1'b0;
      for (int i = 0; i < PORTS; i++) begin
        pop_c[i] = pop_c[i] | gnt[o][i];
        if (gnt[o][i]) begin
          win[o]      = LOG_PORTS'(i);
          win_flit[o] = in_flit[i*FLIT_W +: FLIT_W];
          win_head[o] = in_head[i];
          win_tail[o] = in_tail[i];
        end
      end
    end
  end

  // state may be mid-clear while rst_n is low, so gate the dequeue strobe too
  assign in_pop   = rst_n ? pop_c : '0;
  assign out_flit = flit_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= '0;
      flit_q    <= '0;
      busy      <= '0;
      owner     <= '0;
      ptr       <= '0;
      for (int o = 0; o < PORTS; o++) credit[o] <= CRED_W'(CREDIT_DEPTH);
    end else begin
      out_valid <= gnt_any;
      flit_q    <= win_flit;
      for (int o = 0; o < PORTS; o++) begin
        if (gnt_any[o]) begin
          if (win_head[o]) begin
            ptr[o] <= (int'(win[o]) == PORTS - 1) ? '0 : win[o] + 1'b1;
            if (!win_tail[o]) begin
              busy[o]  <= 1'b1;
              owner[o] <= win[o];
            end
          end else if (win_tail[o]) begin
            busy[o] <= 1'b0;
          end
        end
        case ({gnt_any[o], credit_in[o]})
          2'b10:   credit[o] <= credit[o] - 1'b1;
          2'b01:   if (credit[o] != CRED_W'(CREDIT_DEPTH)) credit[o] <= credit[o] + 1'b1;
          default: ;
        endcase
      end
    end
  end

  for (genvar o = 0; o < PORTS; o++) begin : g_occ
    assign occupied[o*OCC_W + OCC_OWNER_OFS +: LOG_PORTS] = owner[o];
    assign occupied[o*OCC_W + occ_busy_ofs(LOG_PORTS)]    = busy[o];
  end

  for (genvar g = 0; g < PORTS; g++) begin : g_chk
    a_orphan: assert property (@(posedge clk) disable iff (!rst_n) !orphan[g])
      else $error("%s", MSG_ORPHAN);
    a_cred_ovf: assert property (@(posedge clk) disable iff (!rst_n)
      !(credit_in[g] && !gnt_any[g] && credit[g] == CRED_W'(CREDIT_DEPTH)))
      else $error("%s", MSG_CRED_OVF);
  end

endmodule

// File: tb/tb_rr_switch_allocator.sv
// Randomised bench for rr_switch_allocator against a packet-level reference
// model, with directed scenarios for fairness, locking, credits and reset.
module tb_rr_switch_allocator;
  localparam int P = 5, L = 3, FW = 32, CD = 4, CW = 3;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [P-1:0]       in_valid, in_head, in_tail, in_pop, out_valid, credit_in;
  logic [P*L-1:0]     in_dst;
  logic [P*FW-1:0]    in_flit, out_flit;
  logic [P*(1+L)-1:0] occupied;

  always #5 clk = ~clk;

  rr_switch_allocator #(.PORTS(P), .LOG_PORTS(L), .FLIT_W(FW),
                        .CREDIT_DEPTH(CD), .CRED_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_dst(in_dst),
    .in_head(in_head), .in_tail(in_tail), .in_flit(in_flit), .in_pop(in_pop),
    .out_valid(out_valid), .out_flit(out_flit), .credit_in(credit_in),
    .occupied(occupied)
  );

  int n_vec = 0, n_err = 0;
  int m_busy[P], m_owner[P], m_ptr[P], m_cred[P];
  logic [P-1:0]  m_pop, e_val;
  logic [FW-1:0] e_flit[P];
  int g_left[P], g_dst[P];
  bit g_head[P];
  logic [FW-1:0] g_flit[P];

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int o = 0; o < P; o++) begin
      m_busy[o] = 0; m_owner[o] = 0; m_ptr[o] = 0; m_cred[o] = CD;
    end
    m_pop = '0; e_val = '0;
  endtask

  function automatic logic [P*(1+L)-1:0] model_occ();
    logic [P*(1+L)-1:0] v;
    v = '0;
    for (int o = 0; o < P; o++) begin
      v[o*(1+L) +: L] = L'(m_owner[o]);
      v[o*(1+L) + L]  = (m_busy[o] != 0);
    end
    return v;
  endfunction

  // one cycle of the allocation rules, applied to the currently driven inputs
  task automatic model_step();
    m_pop = '0; e_val = '0;
    for (int o = 0; o < P; o++) begin
      int w;
      w = -1;
      for (int k = 0; k < P; k++) begin
        int i;
        i = (m_ptr[o] + k) % P;
        if (w < 0 && in_valid[i] && int'(in_dst[i*L +: L]) == o && m_cred[o] > 0 &&
            ((m_busy[o] != 0) ? (m_owner[o] == i) : in_head[i]))
          w = i;
      end
      if (w >= 0) begin
        m_pop[w] = 1'b1; e_val[o] = 1'b1; e_flit[o] = in_flit[w*FW +: FW];
        if (in_head[w] && !in_tail[w]) begin
          m_busy[o] = 1; m_owner[o] = w; m_ptr[o] = (w + 1) % P;
        end else if (in_head[w]) m_ptr[o] = (w + 1) % P;
        else if (in_tail[w]) m_busy[o] = 0;
      end
      m_cred[o] += (credit_in[o] ? 1 : 0) - ((w >= 0) ? 1 : 0);
    end
  endtask

  task automatic cycle();
    #1;
    model_step();
    chk("pop", in_pop, m_pop);
    @(negedge clk);
    for (int o = 0; o < P; o++) begin
      chk("oval", out_valid[o], e_val[o]);
      if (e_val[o]) chk("oflit", out_flit[o*FW +: FW], e_flit[o]);
    end
    chk("occ", occupied, model_occ());
  endtask

  task automatic in_clr();
    in_valid = '0; in_head = '0; in_tail = '0; credit_in = '0;
  endtask

  task automatic set_in(int i, int d, bit h, bit t, logic [FW-1:0] f);
    in_valid[i] = 1'b1; in_dst[i*L +: L] = L'(d);
    in_head[i] = h; in_tail[i] = t; in_flit[i*FW +: FW] = f;
  endtask

  task automatic refill(int o, int n);
    in_clr();
    repeat (n) begin credit_in[o] = 1'b1; cycle(); end
    credit_in = '0;
  endtask

  initial begin
    int t5_src[6];
    t5_src = '{0, 1, 2, 3, 4, 0};
    in_clr(); in_dst = '0; in_flit = '0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_oval", out_valid, 0);
    chk("rst_occ", occupied, 0);
    cycle();

    // two single-flit packets collide on output 2
    set_in(1, 2, 1, 1, 32'h11); set_in(3, 2, 1, 1, 32'h33);
    #1 chk("t2_pop_a", in_pop, 5'b00010);
    cycle();
    chk("t2_out_a", out_flit[2*FW +: FW], 32'h11);
    in_valid[1] = 1'b0;
    #1 chk("t2_pop_b", in_pop, 5'b01000);
    cycle();
    chk("t2_out_b", out_flit[2*FW +: FW], 32'h33);
    in_clr(); cycle();
    refill(2, 2);

    // 3-flit packet locks output 4 against a competing head
    set_in(2, 4, 1, 1, 32'h2222);
    for (int k = 0; k < 3; k++) begin
      set_in(0, 4, k == 0, k == 2, 32'h4000 + k);
      #1 chk("t3_pop_lock", in_pop, 5'b00001);
      cycle();
    end
    in_valid[0] = 1'b0;
    #1 chk("t3_pop_after", in_pop, 5'b00100);
    cycle();
    refill(4, 4);

    // drain output 1 credits, stall, then resume on a returned credit
    for (int k = 0; k < 4; k++) set_in(k, 1, 1, 1, $urandom);
    for (int k = 0; k < 4; k++) begin
      #1 chk("t4_pop", in_pop, 64'(1) << k);
      cycle();
      in_valid[k] = 1'b0;
    end
    set_in(4, 1, 1, 1, 32'h5555);
    #1 chk("t4_stall", in_pop, 0);
    cycle();
    credit_in[1] = 1'b1;
    cycle();
    credit_in = '0;
    #1 chk("t4_resume", in_pop, 5'b10000);
    cycle();
    refill(1, 4);

    // grant and credit return coincide on output 3
    for (int k = 0; k < 6; k++) begin
      in_clr();
      set_in(t5_src[k], 3, 1, 1, $urandom);
      credit_in[3] = (k == 2);
      #1 chk("t5_pop", in_pop, (k < 5) ? (64'(1) << t5_src[k]) : 64'(0));
      cycle();
    end
    refill(3, 4);

    // reset asserted while output 0 is locked
    set_in(0, 0, 1, 0, 32'hA0);
    cycle();
    set_in(0, 0, 0, 0, 32'hA1);
    rst_n = 1'b0;
    #1;
    chk("t6_occ", occupied, 0);
    chk("t6_oval", out_valid, 0);
    chk("t6_pop", in_pop, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    in_clr();
    set_in(2, 0, 1, 1, 32'hB2);
    #1 chk("t6_fresh", in_pop, 5'b00100);
    cycle();

    // random packet traffic
    in_clr(); m_pop = '0;
    for (int i = 0; i < P; i++) begin g_left[i] = 0; g_dst[i] = 0; g_head[i] = 0; g_flit[i] = '0; end
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < P; i++) begin
        if (m_pop[i]) begin g_left[i]--; g_head[i] = 0; g_flit[i] = $urandom; end
        if (g_left[i] == 0 && $urandom_range(0, 1) == 1) begin
          g_left[i] = $urandom_range(1, 3); g_dst[i] = $urandom_range(0, P - 1);
          g_head[i] = 1; g_flit[i] = $urandom;
        end
        in_valid[i] = (g_left[i] > 0) && ($urandom_range(0, 3) != 0);
        in_dst[i*L +: L] = L'(g_dst[i]);
        in_head[i] = g_head[i];
        in_tail[i] = (g_left[i] == 1);
        in_flit[i*FW +: FW] = g_flit[i];
      end
      for (int o = 0; o < P; o++)
        credit_in[o] = (m_cred[o] < CD) && ($urandom_range(0, 2) == 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
